// File: rtl/key_control_pkg.sv
// Shared encodings and defaults for the push-button control front end.
// Imported by key_debounce and key_control.
package key_control_pkg;

  typedef enum logic {
    STOPPED = 1'b0,
    RUNNING = 1'b1
  } run_state_e;

  typedef enum logic [1:0] {
    SEL_FULL    = 2'b00,
    SEL_1HZ     = 2'b01,
    SEL_HALF    = 2'b10,
    SEL_QUARTER = 2'b11
  } sel_e;

  // 20 ms of stable level at 50 MHz.
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 1_000_000;
  localparam int unsigned CNT_W_DEF           = 20;

  // The select code wraps from 11 back to 00.
  function automatic logic [1:0] next_select(input logic [1:0] sel);
    return sel + 2'd1;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One raw active-low key: two-flop synchroniser, stable-count debounce and a
// registered strobe on each accepted press (debounced 1->0 transition).
module key_debounce
  import key_control_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned CNT_W           = CNT_W_DEF
) (
  input  logic Clock,
  input  logic reset_n,
  input  logic key_n,
  output logic level,
  output logic fall_strobe
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fall_q, fall_d;

  always_comb begin
    s1_d    = key_n;
    s2_d    = s1_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    // Any cycle where the synchronised level agrees with db restarts the count.
    if (s2_q == level_q) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (cnt_q == LIMIT) begin
      level_d = s2_q;
      cnt_d   = {CNT_W{1'b0}};
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    fall_d = level_q & ~level_d;
  end

  always_ff @(posedge Clock) begin
    if (!reset_n) begin
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= {CNT_W{1'b0}};
      fall_q  <= 1'b0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      fall_q  <= fall_d;
    end
  end

  assign level       = level_q;
  assign fall_strobe = fall_q;

endmodule

// File: rtl/key_control.sv
// Button-driven control for the rate divider and display counter: frequency
// select, run/pause enable and a one-cycle active-low clear.
module key_control
  import key_control_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned CNT_W           = CNT_W_DEF,
  parameter logic [1:0]  SEL_INIT        = 2'b01
) (
  input  logic       Clock,
  input  logic       reset_n,
  input  logic       key_speed_n,
  input  logic       key_pause_n,
  input  logic       key_clear_n,
  output logic [1:0] select,
  output logic       enable,
  output logic       clear_n,
  output logic [2:0] press
);

  logic [2:0] key_n_s;
  logic [2:0] level_s;
  logic [2:0] fall_s;
  logic [2:0] event_s;

  assign key_n_s = {key_clear_n, key_pause_n, key_speed_n};

  for (genvar k = 0; k < 3; k++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_db (
      .Clock      (Clock),
      .reset_n    (reset_n),
      .key_n      (key_n_s[k]),
      .level      (level_s[k]),
      .fall_strobe(fall_s[k])
    );
  end

  // A strobe is only honoured while the debounced key is settled low.
  assign event_s = fall_s & ~level_s;

  logic [1:0] select_q, select_d;
  run_state_e run_q, run_d;
  logic       clear_n_q, clear_n_d;

  always_comb begin
    select_d  = select_q;
    run_d     = run_q;
    clear_n_d = 1'b1;
    if (event_s[0]) begin
      select_d = next_select(select_q);
    end else begin
      select_d = select_q;
    end
    if (event_s[1]) begin
      case (run_q)
        STOPPED: run_d = RUNNING;
        RUNNING: run_d = STOPPED;
        default: run_d = STOPPED;
      endcase
    end else begin
      run_d = run_q;
    end
    if (event_s[2]) begin
      clear_n_d = 1'b0;
    end else begin
      clear_n_d = 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (!reset_n) begin
      select_q  <= SEL_INIT;
      run_q     <= STOPPED;
      clear_n_q <= 1'b1;
    end else begin
      select_q  <= select_d;
      run_q     <= run_d;
      clear_n_q <= clear_n_d;
    end
  end

  assign select  = select_q;
  assign enable  = (run_q == RUNNING);
  assign clear_n = clear_n_q;
  assign press   = fall_s;

endmodule

// File: doc/key_control.md
Name: key_control

Overview:
- Upstream input stage for the seconds/hex display block.
- Conditions three raw active-low push buttons: 2-flop synchronise, then debounce.
- Turns debounced presses into the control signals the rate-divider and display-counter stage consumes:
  - a 2-bit frequency select (cycled by a button),
  - a run/pause enable (toggled by a button),
  - a one-cycle synchronous active-low clear.
- Replaces direct slide-switch control of that stage.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles needed to accept a level change (20 ms at 50 MHz); legal range 2 to 2^CNT_W-1.
- CNT_W, 20, width of each debounce counter.
- SEL_INIT, 2'b01, select value after reset.

Ports:
- Clock  in  1  system clock, 50 MHz.
- reset_n  in  1  synchronous, active-low reset.
- key_speed_n  in  1  raw button, asynchronous, low = pressed; each press advances select.
- key_pause_n  in  1  raw button, asynchronous, low = pressed; each press toggles run state.
- key_clear_n  in  1  raw button, asynchronous, low = pressed; each press issues a clear pulse.
- select  out  2  frequency select to the rate divider (00 full rate, 01/10/11 progressively slower).
- enable  out  1  run enable to the rate divider; 1 = RUNNING.
- clear_n  out  1  synchronous active-low clear to the divider and display counter; low for exactly one cycle per accepted clear press.
- press  out  3  one-cycle press strobes {clear, pause, speed}, for debug and LEDs.

Behaviour:
- Reset, applied on any Clock edge with reset_n = 0, regardless of in-progress activity:
  - sync flops = 1, debounced levels = 1, counters = 0;
  - select = SEL_INIT, run state = STOPPED, enable = 0, clear_n = 1, press = 000;
  - no strobe is generated by reset or by its release.
- Synchroniser: two flops per key; s2 is the synchronised level.
- Debounce, per key:
  - if s2 == db: counter <= 0;
  - else if counter == DEBOUNCE_CYCLES-1: db <= s2, counter <= 0;
  - else counter <= counter+1.
  - Any single-cycle return to db restarts the count (glitch rejection).
- Press strobe:
  - registered; set on the same edge db goes 1->0, cleared the next edge.
  - The release edge (0->1) produces no strobe.
  - A held key yields exactly one strobe.
- Latency: raw key first sampled low at edge E and held low -> strobe high in the cycle after edge E+DEBOUNCE_CYCLES+1; control outputs change on the following edge (E+DEBOUNCE_CYCLES+2).
- Speed FSM: on speed strobe, select <= select+1 mod 4 (11 wraps to 00).
- Run FSM, states STOPPED (enable 0) and RUNNING (enable 1): pause strobe toggles the state; no other transitions.
- Clear: on clear strobe, clear_n <= 0 for one cycle, then 1. Clear does not alter select or run state.
- Simultaneous strobes are independent; all take effect on the same edge.
- All outputs are registered; no combinational path from any key to any output.
- Counter arithmetic is unsigned CNT_W bits; the comparison is against DEBOUNCE_CYCLES-1 truncated to CNT_W.

Decomposition:
- Shared package:
  - run-state encoding (STOPPED=1'b0, RUNNING=1'b1);
  - select encodings (SEL_FULL=00, SEL_1HZ=01, SEL_HALF=10, SEL_QUARTER=11);
  - default DEBOUNCE_CYCLES constant.
- One sub-module, key_debounce:
  - ports: Clock, reset_n, key_n, level, fall_strobe; parameters DEBOUNCE_CYCLES, CNT_W;
  - instantiated three times.
- key_control holds only the speed/run/clear registers.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset: hold reset_n=0 for 3 cycles with all keys high, then release -> select=01, enable=0, clear_n=1, press=000, and all stay there for 20 cycles.
- Speed wrap: 4 clean presses of key_speed_n (each low 10 cycles, high 10 cycles) -> select steps 10, 11, 00, 01; exactly 4 speed strobes; first strobe in the cycle after edge E+5.
- Bounce rejection: key_pause_n toggles low/high every cycle for 12 cycles, then held low for 10 cycles -> exactly one pause strobe, and it follows the stable period; enable goes 0->1 once. A further 3-cycle low glitch -> no change.
- Held key and release: key_pause_n low for 50 cycles, then high -> one strobe only (enable 1->0 if starting RUNNING); no strobe on release.
- Clear and simultaneous events: press key_clear_n and key_speed_n together in the same cycle -> clear_n low for exactly one cycle, on the same edge select increments; enable unchanged.
- Reset mid-debounce: key_speed_n low for 3 cycles, then reset_n=0 for one edge while the key stays low -> no strobe from the pre-reset count; a fresh strobe arrives 6 cycles after reset release; select = 10.
